fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one synchronous FIFO write port among `N_REQ` requesters. Each requester offers words over a valid/ready handshake with a `last` marker. The arbiter locks the grant for a whole packet, so packets from different sources never interleave in the FIFO. Each FIFO entry is tagged with the source ID. The block sits directly in front of the `fifo` write port (`wr_en`/`wr_data`/`full`) and adds zero cycles of latency.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 99 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter and its priority picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int PKT_CNT_W = 16;

    // Keeps tag fields at least one bit wide even for tiny requester counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of req starting at prio, wrapping at N_REQ.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int ID_W = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  prio,
    output logic [ID_W-1:0]  sel,
    output logic             any
);

    int idx;

    // Scan from the farthest offset down so the nearest hit to prio wins.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(prio) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req[idx]) begin
                sel = ID_W'(idx);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locking round-robin arbiter sharing one FIFO write port among N_REQ requesters.
//   state | meaning
//   IDLE  | no packet open, grant follows round-robin pick from prio
//   LOCK  | packet open, grant pinned to lock_id until its last word
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int ID_W = clog2_min1(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     fifo_wr_en,
    output logic [ID_W+WIDTH-1:0]    fifo_wr_data,
    input  logic                     fifo_full,
    output logic [ID_W-1:0]          grant_id,
    output logic                     locked,
    output logic [PKT_CNT_W-1:0]     pkt_count
);

    arb_state_t           state_q, state_d;
    logic [ID_W-1:0]      prio_q, prio_d;
    logic [ID_W-1:0]      lock_id_q, lock_id_d;
    logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;

    logic [ID_W-1:0] pick_sel;
    logic            pick_any;
    logic [ID_W-1:0] sel;
    logic            sel_valid;
    logic            acc;

    rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
        .req  (req_valid),
        .prio (prio_q),
        .sel  (pick_sel),
        .any  (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= '0;
            lock_id_q   <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            lock_id_q   <= lock_id_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        lock_id_d   = lock_id_q;
        pkt_count_d = pkt_count_q;
        req_ready   = '0;

        if (state_q == LOCK) begin
            sel       = lock_id_q;
            sel_valid = req_valid[lock_id_q];
        end else begin
            sel       = pick_sel;
            sel_valid = pick_any;
        end

        // Full is folded into the accept so a stalled FIFO can never be overrun.
        acc = sel_valid && !fifo_full;
        if (acc) begin
            req_ready[sel] = 1'b1;
        end

        if (acc && req_last[sel]) begin
            state_d     = IDLE;
            pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
            if (int'(sel) == N_REQ - 1) begin
                prio_d = '0;
            end else begin
                prio_d = sel + ID_W'(1);
            end
        end else if (acc && state_q == IDLE) begin
            state_d   = LOCK;
            lock_id_d = sel;
        end
    end

    assign fifo_wr_en   = acc;
    assign fifo_wr_data = {sel, req_data[sel*WIDTH +: WIDTH]};
    assign grant_id     = sel;
    assign locked       = (state_q == LOCK);
    assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: packet-level round-robin model checked every cycle plus literal scenario checks.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_en;
    logic [9:0]     fifo_wr_data;
    logic           fifo_full;
    logic [1:0]     grant_id;
    logic           locked;
    logic [15:0]    pkt_count;

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .locked       (locked),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-requester word sources: {last, data}
    logic [8:0] mem [N][32];
    int         head [N];
    int         tail [N];
    logic [N-1:0] en;

    // Packet-level model of the arbiter
    int m_open, m_owner, m_prio, m_cnt;
    int s_acc, s_sel, s_last;
    int lock_cycles;

    logic [9:0] wlog [$];
    logic [9:0] elog [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) begin
            if (en[i] && head[i] != tail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*W +: W] = mem[i][head[i]][7:0];
                req_last[i]        = mem[i][head[i]][8];
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    task automatic model_reset();
        m_open  = 0;
        m_owner = 0;
        m_prio  = 0;
        m_cnt   = 0;
        s_acc   = 0;
    endtask

    task automatic compare_cycle();
        int e_sel, e_valid, e_acc;
        logic [N-1:0] e_ready;
        logic [9:0]   e_wd;
        if (rst) model_reset();
        e_sel = 0;
        e_valid = 0;
        if (m_open != 0) begin
            e_sel   = m_owner;
            e_valid = int'(req_valid[m_owner]);
        end else begin
            for (int off = 0; off < N; off++) begin
                int idx;
                idx = (m_prio + off) % N;
                if (req_valid[idx] && e_valid == 0) begin
                    e_sel   = idx;
                    e_valid = 1;
                end
            end
        end
        e_acc = (e_valid != 0 && !fifo_full) ? 1 : 0;
        e_ready = '0;
        if (e_acc != 0) e_ready[e_sel] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("fifo_wr_en", 32'(fifo_wr_en), 32'(e_acc));
        check("grant_id", 32'(grant_id), 32'(e_sel));
        check("locked", 32'(locked), 32'(m_open));
        check("pkt_count", 32'(pkt_count), 32'(m_cnt));
        if (e_acc != 0) begin
            e_wd = {2'(e_sel), req_data[e_sel*W +: W]};
            check("fifo_wr_data", 32'(fifo_wr_data), 32'(e_wd));
        end
        s_acc  = e_acc;
        s_sel  = e_sel;
        s_last = int'(req_last[e_sel]);
        if (!rst) begin
            if (fifo_wr_en) wlog.push_back(fifo_wr_data);
            if (locked) lock_cycles++;
        end
    endtask

    task automatic update_cycle();
        if (!rst && s_acc != 0) begin
            if (s_last != 0) begin
                m_open = 0;
                m_prio = (s_sel + 1) % N;
                m_cnt  = (m_cnt + 1) % 65536;
            end else begin
                m_open  = 1;
                m_owner = s_sel;
            end
            head[s_sel]++;
        end
        drive_inputs();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_cycle();
            @(posedge clk);
            #1;
            update_cycle();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (k < 200 && (head[0] != tail[0] || head[1] != tail[1] ||
                           head[2] != tail[2] || head[3] != tail[3])) begin
            tick(1);
            k++;
        end
        check({nm, "_drain_timeout"}, 32'(k < 200), 32'd1);
        tick(1);
    endtask

    task automatic check_log(input string nm);
        check({nm, "_log_len"}, 32'(wlog.size()), 32'(elog.size()));
        for (int i = 0; i < elog.size(); i++) begin
            if (i < wlog.size()) check({nm, "_log_entry"}, 32'(wlog[i]), 32'(elog[i]));
        end
        wlog.delete();
        elog.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        en = '1;
        fifo_full = 1'b0;
        rst = 1'b1;
        model_reset();
        lock_cycles = 0;
        drive_inputs();
        #12;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        #5 rst = 1'b0;
        tick(1);

        // Single requester, 3-word packet
        wlog.delete();
        lock_cycles = 0;
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
        drive_inputs();
        drain("single");
        elog.push_back({2'd2, 8'h11}); elog.push_back({2'd2, 8'h22}); elog.push_back({2'd2, 8'h33});
        check_log("single");
        check("single_lock_cycles", 32'(lock_cycles), 32'd2);
        check("single_pkt_count", 32'(pkt_count), 32'd1);

        // Fairness: prio now 3, so service starts at requester 3
        for (int r = 0; r < N; r++) begin
            push(r, 8'(8'h80 + r), 1'b1);
            push(r, 8'(8'h90 + r), 1'b1);
        end
        drive_inputs();
        repeat (8) @(negedge clk);
        #1;
        check("fair_back_to_back", 32'(wlog.size()), 32'd8);
        drain("fair");
        elog.push_back({2'd3, 8'h83});
        elog.push_back({2'd0, 8'h80}); elog.push_back({2'd1, 8'h81});
        elog.push_back({2'd2, 8'h82}); elog.push_back({2'd3, 8'h93});
        elog.push_back({2'd0, 8'h90}); elog.push_back({2'd1, 8'h91});
        elog.push_back({2'd2, 8'h92});
        check_log("fair");
        check("fair_pkt_count", 32'(pkt_count), 32'd9);

        // Packet lock: requester 0 arrives while requester 1 is mid-packet
        push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b0); push(1, 8'hA4, 1'b1);
        drive_inputs();
        tick(1);
        push(0, 8'h05, 1'b1);
        drive_inputs();
        @(negedge clk);
        #1;
        check("lock_req0_blocked", 32'(req_ready[0]), 32'd0);
        tick(1);
        drain("lock");
        elog.push_back({2'd1, 8'hA1}); elog.push_back({2'd1, 8'hA2});
        elog.push_back({2'd1, 8'hA3}); elog.push_back({2'd1, 8'hA4});
        elog.push_back({2'd0, 8'h05});
        check_log("lock");
        check("lock_pkt_count", 32'(pkt_count), 32'd11);

        // Full stall for 5 cycles mid-packet
        push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b0); push(3, 8'h33, 1'b1);
        drive_inputs();
        tick(1);
        fifo_full = 1'b1;
        @(negedge clk);
        #1;
        check("stall_grant", 32'(grant_id), 32'd3);
        check("stall_wr_en", 32'(fifo_wr_en), 32'd0);
        check("stall_ready", 32'(req_ready), 32'd0);
        check("stall_locked", 32'(locked), 32'd1);
        tick(5);
        fifo_full = 1'b0;
        drain("stall");
        elog.push_back({2'd3, 8'h31}); elog.push_back({2'd3, 8'h32}); elog.push_back({2'd3, 8'h33});
        check_log("stall");
        check("stall_pkt_count", 32'(pkt_count), 32'd12);

        // Bubble: locked requester 2 drops valid, requester 1 must wait
        push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
        drive_inputs();
        tick(1);
        en[2] = 1'b0;
        push(1, 8'h51, 1'b1);
        drive_inputs();
        @(negedge clk);
        #1;
        check("bubble_locked", 32'(locked), 32'd1);
        check("bubble_wr_en", 32'(fifo_wr_en), 32'd0);
        check("bubble_ready", 32'(req_ready), 32'd0);
        tick(2);
        en[2] = 1'b1;
        drive_inputs();
        drain("bubble");
        elog.push_back({2'd2, 8'h41}); elog.push_back({2'd2, 8'h42});
        elog.push_back({2'd2, 8'h43}); elog.push_back({2'd1, 8'h51});
        check_log("bubble");
        check("bubble_pkt_count", 32'(pkt_count), 32'd14);

        // Async reset mid-packet
        push(3, 8'h61, 1'b0); push(3, 8'h62, 1'b0); push(3, 8'h63, 1'b0); push(3, 8'h64, 1'b1);
        drive_inputs();
        tick(1);
        push(1, 8'h71, 1'b1);
        drive_inputs();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_pkt_count", 32'(pkt_count), 32'd0);
        check("arst_grant", 32'(grant_id), 32'd1);
        check("arst_wr_data", 32'(fifo_wr_data), 32'({2'd1, 8'h71}));
        @(posedge clk);
        #3;
        rst = 1'b0;
        wlog.delete();
        elog.delete();
        drain("arst");
        elog.push_back({2'd1, 8'h71}); elog.push_back({2'd3, 8'h63}); elog.push_back({2'd3, 8'h64});
        check_log("arst");
        check("arst_pkt_count_after", 32'(pkt_count), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
